rgb_fade_seq: RTL and testbench

RGB_FADE_SEQ -- requirements
Module: rgb_fade_seq

---
 rtl/rgb_fade_seq.sv | 163 ++++++++++++++++
 tb/tb_rgb_fade_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_seq.sv
// RGB LED fade sequencer: queues colour commands and ramps three PWM duty
// levels toward each target at a bounded per-tick rate, then optionally holds.
module rgb_fade_seq #(
  parameter int unsigned TICK_DIV   = 187500,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_rgb,
  input  logic [7:0]  cmd_rate,
  input  logic [7:0]  cmd_hold,
  input  logic        abort,
  output logic [7:0]  r_level,
  output logic [7:0]  g_level,
  output logic [7:0]  b_level,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] TICK_LAST  = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FADE, HOLD} state_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic [7:0]  rate;
    logic [7:0]  hold;
  } cmd_t;

  state_t        state, state_next;
  logic [DW-1:0] presc;
  logic          tick;
  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop, finish, pending;
  logic [23:0]   tgt, levels, stepped;
  logic [7:0]    rate_q, hold_cnt;

  // One channel step toward the target; the 9-bit intermediate keeps a large
  // rate from wrapping past 0 or 255 before the clamp.
  function automatic logic [7:0] step_toward(input logic [7:0] level,
                                             input logic [7:0] target,
                                             input logic [7:0] rate);
    logic [8:0] up;
    logic [8:0] down;
    up   = {1'b0, level} + {1'b0, rate};
    down = {1'b0, level} - {1'b0, rate};
    if (level < target)
      step_toward = (up > {1'b0, target}) ? target : up[7:0];
    else if (level > target)
      step_toward = (down[8] || (down[7:0] < target)) ? target : down[7:0];
    else
      step_toward = level;
  endfunction

  assign tick    = (presc == TICK_LAST);
  assign head    = mem[rd_ptr];
  assign push    = cmd_valid && cmd_ready && !abort;
  assign pending = (state == LOAD) ? (count > CW'(1)) : (count != '0);
  assign stepped = {step_toward(levels[23:16], tgt[23:16], rate_q),
                    step_toward(levels[15:8],  tgt[15:8],  rate_q),
                    step_toward(levels[7:0],   tgt[7:0],   rate_q)};
  assign {r_level, g_level, b_level} = levels;
  assign done       = finish;
  assign count_next = abort ? '0 : (count + CW'(push) - CW'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_rgb, cmd_rate, cmd_hold};
  end

  // Ready is registered from the post-update count, so it never sees a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      count     <= count_next;
      cmd_ready <= (count_next != FULL_COUNT);
    end
  end

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: if (count != '0) state_next = LOAD;
      LOAD: begin
        pop = 1'b1;
        if (head.rate != 8'd0) state_next = FADE;
        else if (head.hold != 8'd0) state_next = HOLD;
        else finish = 1'b1;
      end
      FADE: if (levels == tgt) begin
        if (hold_cnt != 8'd0) state_next = HOLD;
        else finish = 1'b1;
      end
      HOLD: if (hold_cnt == 8'd0) finish = 1'b1;
      default: state_next = IDLE;
    endcase
    if (finish) state_next = pending ? LOAD : IDLE;
    if (abort) begin
      state_next = IDLE;
      finish     = 1'b0;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      levels   <= '0;
      tgt      <= '0;
      rate_q   <= '0;
      hold_cnt <= '0;
    end else if (!abort) begin
      unique case (state)
        LOAD: begin
          tgt      <= head.rgb;
          rate_q   <= head.rate;
          hold_cnt <= head.hold;
          if (head.rate == 8'd0) levels <= head.rgb;
        end
        FADE: if (tick) levels <= stepped;
        HOLD: if (tick && hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Bench for rgb_fade_seq: directed scenarios plus a random command stream,
// scored against a transaction-level fade model kept beside the DUT.
module tb_rgb_fade_seq;

  localparam int TICK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstN, cmdValid, cmdReady, abortIn, busy, done;
  logic [23:0] cmdRgb;
  logic [7:0]  cmdRate, cmdHold, rLevel, gLevel, bLevel;

  typedef struct {
    logic [23:0] rgb;
    int          rate;
    int          hold;
  } cmd_s;

  cmd_s        expQ[$];
  cmd_s        lastDoneCmd, govCmd;
  bit          lastDoneValid, abortPrev, govValid;
  int          doneCount, edgeCnt, checkCount, errorCount;
  logic [23:0] prevLevels, monLevels, monExpect;

  rgb_fade_seq #(.TICK_DIV(TICK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rstN), .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .cmd_rgb(cmdRgb), .cmd_rate(cmdRate), .cmd_hold(cmdHold), .abort(abortIn),
    .r_level(rLevel), .g_level(gLevel), .b_level(bLevel), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Offers one command and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [23:0] rgb, input logic [7:0] rate, input logic [7:0] hold);
    bit accepted;
    accepted = 1'b0;
    cmdRgb   = rgb;
    cmdRate  = rate;
    cmdHold  = hold;
    cmdValid = 1'b1;
    for (int c = 0; c < 2000 && !accepted; c++) begin
      accepted = cmdReady;
      stepClock();
    end
    cmdValid = 1'b0;
    checkOutput("accept_in_time", accepted, 1);
  endtask

  task automatic waitIdle(input int maxCycles);
    int quiet;
    quiet = 0;
    for (int c = 0; c < maxCycles && quiet < 3; c++) begin
      stepClock();
      if (!busy) quiet++;
      else quiet = 0;
    end
    checkOutput("idle_reached", (quiet >= 3), 1);
  endtask

  function automatic int towards(int lv, int tg, int rt);
    if (rt == 0) return tg;
    if (lv < tg) return (lv + rt > tg) ? tg : lv + rt;
    if (lv > tg) return (lv - rt < tg) ? tg : lv - rt;
    return lv;
  endfunction

  function automatic logic [23:0] stepModel(input logic [23:0] lv, input cmd_s c);
    return {8'(towards(int'(lv[23:16]), int'(c.rgb[23:16]), c.rate)),
            8'(towards(int'(lv[15:8]),  int'(c.rgb[15:8]),  c.rate)),
            8'(towards(int'(lv[7:0]),   int'(c.rgb[7:0]),   c.rate))};
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rstN) edgeCnt = 0;
    else edgeCnt++;
  end

  // Scoreboard: every level change must be one legal step of the command in
  // force, fade steps must land on tick edges, and each done retires the
  // oldest accepted command with the levels sitting on its target.
  initial begin
    prevLevels = '0;
    forever begin
      @(negedge clk);
      monLevels = {rLevel, gLevel, bLevel};
      if (!rstN) begin
        expQ.delete();
        lastDoneValid = 1'b0;
        abortPrev     = 1'b0;
      end else begin
        govValid = lastDoneValid || (expQ.size() != 0);
        if (lastDoneValid) govCmd = lastDoneCmd;
        else if (expQ.size() != 0) govCmd = expQ[0];
        if (monLevels != prevLevels) begin
          monExpect = (abortPrev || !govValid) ? prevLevels : stepModel(prevLevels, govCmd);
          checkOutput("level_step", monLevels, monExpect);
          if (govValid && !abortPrev && govCmd.rate != 0)
            checkOutput("tick_phase", (edgeCnt - 1) % TICK_DIV, TICK_DIV - 1);
        end
        if (lastDoneValid) checkOutput("done_target", monLevels, lastDoneCmd.rgb);
        lastDoneValid = 1'b0;
        abortPrev     = 1'b0;
        if (abortIn) begin
          checkOutput("abort_no_done", done, 0);
          expQ.delete();
          abortPrev = 1'b1;
        end else begin
          if (done) begin
            if (expQ.size() == 0) checkOutput("done_without_cmd", done, 0);
            else begin
              lastDoneCmd   = expQ.pop_front();
              lastDoneValid = 1'b1;
              doneCount++;
            end
          end
          if (cmdValid && cmdReady) expQ.push_back('{cmdRgb, int'(cmdRate), int'(cmdHold)});
        end
      end
      prevLevels = monLevels;
    end
  end

  initial begin
    #5_000_000;
    errorCount++;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] seen [3];
    int          seenAt [3];
    int          nChg, lat, doneBefore;
    bit          doneAtLast;
    logic [23:0] cur, prev;

    rstN = 1'b0; cmdValid = 1'b0; abortIn = 1'b0;
    cmdRgb = '0; cmdRate = '0; cmdHold = '0;
    #2;
    checkOutput("reset_outputs", {rLevel, gLevel, bLevel, busy, done, cmdReady}, 0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    checkOutput("ready_before_edge", cmdReady, 0);
    stepClock();
    checkOutput("ready_after_edge", cmdReady, 1);

    // Instant jump: LOAD two edges after acceptance, done there, idle next.
    applyStimulus(24'hFF0000, 8'd0, 8'd0);
    checkOutput("idle_after_accept", busy, 0);
    stepClock();
    checkOutput("jump_load_busy", busy, 1);
    checkOutput("jump_load_done", done, 1);
    stepClock();
    checkOutput("jump_level", {rLevel, gLevel, bLevel}, 24'hFF0000);
    checkOutput("jump_idle", busy, 0);
    checkOutput("jump_done_pulse", done, 0);

    applyStimulus(24'h000000, 8'd0, 8'd0);
    waitIdle(50);

    // Rate-limited fade from black.
    applyStimulus(24'h0A0300, 8'd4, 8'd0);
    nChg = 0; doneAtLast = 1'b0;
    prev = {rLevel, gLevel, bLevel};
    for (int c = 0; c < 100; c++) begin
      cur = {rLevel, gLevel, bLevel};
      if (cur != prev) begin
        if (nChg < 3) begin
          seen[nChg]   = cur;
          seenAt[nChg] = c;
        end
        if (cur == 24'h0A0300) doneAtLast = done;
        nChg++;
      end
      prev = cur;
      if (done) break;
      stepClock();
    end
    checkOutput("fade_steps", nChg, 3);
    checkOutput("fade_step1", seen[0], 24'h040300);
    checkOutput("fade_step2", seen[1], 24'h080300);
    checkOutput("fade_step3", seen[2], 24'h0A0300);
    checkOutput("fade_gap12", seenAt[1] - seenAt[0], TICK_DIV);
    checkOutput("fade_gap23", seenAt[2] - seenAt[1], TICK_DIV);
    checkOutput("fade_done_after_tick", doneAtLast, 1);
    stepClock();
    checkOutput("fade_done_pulse", done, 0);
    checkOutput("fade_idle", busy, 0);

    // FIFO fill behind a long hold.
    applyStimulus(24'h111111, 8'd0, 8'd20);
    stepClock(); stepClock();
    doneBefore = doneCount;
    for (int i = 0; i < 4; i++) applyStimulus(24'h010203 * (i + 1), 8'd0, 8'd0);
    checkOutput("ready_full", cmdReady, 0);
    lat = doneCount;
    applyStimulus(24'h0A0B0C, 8'd0, 8'd0);
    checkOutput("stall_until_pop", (doneCount > lat), 1);
    waitIdle(500);
    checkOutput("fifo_done_pulses", doneCount - doneBefore, 6);
    checkOutput("fifo_last_level", {rLevel, gLevel, bLevel}, 24'h0A0B0C);

    // Abort mid-fade with a command queued and another offered.
    applyStimulus(24'h000000, 8'd0, 8'd0);
    waitIdle(50);
    applyStimulus(24'h202020, 8'd1, 8'd3);
    applyStimulus(24'hABCDEF, 8'd0, 8'd0);
    for (int c = 0; c < 400 && rLevel != 8'h10; c++) stepClock();
    checkOutput("abort_reach_level", rLevel, 8'h10);
    doneBefore = doneCount;
    abortIn = 1'b1;
    cmdRgb = 24'h777777; cmdRate = 8'd0; cmdHold = 8'd0; cmdValid = 1'b1;
    stepClock();
    abortIn = 1'b0; cmdValid = 1'b0;
    checkOutput("abort_levels", {rLevel, gLevel, bLevel}, 24'h101010);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    repeat (20) stepClock();
    checkOutput("abort_frozen", {rLevel, gLevel, bLevel}, 24'h101010);
    checkOutput("abort_stays_idle", busy, 0);
    checkOutput("abort_queue_lost", doneCount - doneBefore, 0);
    checkOutput("abort_ready", cmdReady, 1);

    // Oversized rates must clamp on the target.
    applyStimulus(24'hFFFFFF, 8'd255, 8'd0);
    waitIdle(100);
    checkOutput("clamp_up", {rLevel, gLevel, bLevel}, 24'hFFFFFF);
    applyStimulus(24'h01FE00, 8'd200, 8'd0);
    waitIdle(100);
    checkOutput("clamp_mixed", {rLevel, gLevel, bLevel}, 24'h01FE00);

    // Target equal to the current levels completes without waiting for a tick.
    applyStimulus(24'h01FE00, 8'd5, 8'd0);
    lat = 0;
    while (!done && lat < 10) begin
      stepClock();
      lat++;
    end
    checkOutput("equal_target_latency", (lat >= 2 && lat <= 3), 1);
    waitIdle(50);

    // Asynchronous reset in the middle of a hold.
    applyStimulus(24'h404040, 8'd0, 8'd10);
    repeat (6) stepClock();
    #3 rstN = 1'b0;
    #1;
    checkOutput("async_reset", {rLevel, gLevel, bLevel, busy, done, cmdReady}, 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    checkOutput("ready_before_edge2", cmdReady, 0);
    stepClock();
    checkOutput("ready_after_edge2", cmdReady, 1);
    repeat (30) stepClock();
    checkOutput("no_resume", {rLevel, gLevel, bLevel, busy}, 0);

    // Random command stream.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 6)) stepClock();
      applyStimulus(24'($urandom),
                    ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(4, 255)),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 4)) : 8'd0);
      if ($urandom_range(0, 5) == 0) waitIdle(4000);
    end
    waitIdle(4000);
    stepClock();
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
